// File: rtl/care_sched_pkg.sv
// care_sched_pkg -- shared types and constants for the care scheduler.
//   sched_state_t : FSM state encoding
//   stat indices  : HUNGER..SOCIAL (0..5), NUM_STATS
//   op codes      : OP_DEC / OP_INC
//   DECAY_AMT     : magnitude of each decay step
//   lowest_set()  : index of the lowest set bit of a stat mask (fixed priority)
package care_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACT   = 2'd1,
      DECAY = 2'd2,
      COOL  = 2'd3
   } sched_state_t;

   localparam int NUM_STATS = 6;

   localparam logic [2:0] HUNGER    = 3'd0;
   localparam logic [2:0] HAPPINESS = 3'd1;
   localparam logic [2:0] HEALTH    = 3'd2;
   localparam logic [2:0] HYGIENE   = 3'd3;
   localparam logic [2:0] ENERGY    = 3'd4;
   localparam logic [2:0] SOCIAL    = 3'd5;

   localparam logic OP_DEC = 1'b0;
   localparam logic OP_INC = 1'b1;

   localparam logic [3:0] DECAY_AMT = 4'd1;

   // Walk from the top down so the lowest set index wins.
   function automatic logic [2:0] lowest_set(input logic [NUM_STATS-1:0] v);
      lowest_set = HUNGER;
      for (int i = NUM_STATS - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = 3'(i);
      end
   endfunction

endpackage

// File: rtl/care_scheduler_btn_edge_latch.sv
// btn_edge_latch -- rising-edge detector with sticky pending bits.
//   clk, rst_n : clock, async active-low reset
//   btn_in     : raw button levels
//   clr_mask   : one-hot clear of the bit being granted this cycle
//   pend       : pending request bits
// A rise arriving in the same cycle as its clear wins, so a press during the
// grant cycle is not lost.
module btn_edge_latch
   import care_sched_pkg::*;
#(
   parameter int W = NUM_STATS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] btn_in,
   input  logic [W-1:0] clr_mask,
   output logic [W-1:0] pend
);

   logic [W-1:0] btn_q;
   logic [W-1:0] rise;

   assign rise = btn_in & ~btn_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q <= '0;
         pend  <= '0;
      end else begin
         btn_q <= btn_in;
         pend  <= (pend & ~clr_mask) | rise;
      end
   end

endmodule

// File: rtl/care_scheduler.sv
// care_scheduler -- arbitrates care-button actions and periodic stat decay
// onto a single valid/ready update port.
//   clk, rst_n      : clock, async active-low reset
//   ena             : enables prescaler and new grants
//   btn_in[5:0]     : care buttons, bit i -> stat i
//   rand_in[3:0]    : random source, [1:0] sets action magnitude
//   upd_valid/ready : update handshake
//   upd_stat/op/amt : update target, direction, magnitude
//   tick            : one-cycle pulse per decay period
//   busy            : FSM not idle
// Optional build macro SCHED_STARVE_GUARD_EN: after 4 consecutive action
// grants with a decay outstanding, the decay is granted ahead of actions.
//
// state | meaning
// IDLE  | waiting; grants an action or a decay sweep when ena=1
// ACT   | presenting one increment update until accepted
// DECAY | sweeping decrement updates over stats 0..5
// COOL  | lockout after an action, COOLDOWN cycles
module care_scheduler
   import care_sched_pkg::*;
#(
   parameter logic [23:0] TICK_COUNT = 24'd10_000_000,
   parameter logic [7:0]  COOLDOWN   = 8'd16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [5:0] btn_in,
   input  logic [3:0] rand_in,
   output logic       upd_valid,
   input  logic       upd_ready,
   output logic [2:0] upd_stat,
   output logic       upd_op,
   output logic [3:0] upd_amt,
   output logic       tick,
   output logic       busy
);

   sched_state_t state, state_nxt;

   logic [23:0] presc, presc_nxt;
   logic        decay_pend, decay_pend_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [2:0]  stat_r, stat_nxt;
   logic        op_r, op_nxt;
   logic [3:0]  amt_r, amt_nxt;

   logic [NUM_STATS-1:0] act_pend;
   logic [NUM_STATS-1:0] clr_mask;
   logic                 grant_act;
   logic                 grant_decay;
   logic                 starve;
   logic [2:0]           act_idx;

   // Only the low two random bits set the action magnitude.
   logic unused_rand;
   assign unused_rand = ^rand_in[3:2];

   btn_edge_latch #(.W(NUM_STATS)) u_btn (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_in   (btn_in),
      .clr_mask (clr_mask),
      .pend     (act_pend)
   );

   assign act_idx = lowest_set(act_pend);

   // Prescaler: counts only while enabled, tick at terminal count.
   assign tick = ena && (presc == TICK_COUNT - 24'd1);

   always_comb begin
      presc_nxt = presc;
      if (ena) presc_nxt = tick ? 24'd0 : presc + 24'd1;
   end

   // A decay grant consumes the pending flag; a tick landing while it is
   // already set is simply absorbed.
   always_comb begin
      decay_pend_nxt = decay_pend;
      if (grant_decay)  decay_pend_nxt = 1'b0;
      else if (tick)    decay_pend_nxt = 1'b1;
   end

`ifdef SCHED_STARVE_GUARD_EN
   logic [2:0] streak;

   assign starve = (streak == 3'd4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak <= 3'd0;
      end else if (grant_decay) begin
         streak <= 3'd0;
      end else if (grant_act && decay_pend && !starve) begin
         streak <= streak + 3'd1;
      end
   end
`else
   assign starve = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      cnt_nxt     = cnt;
      stat_nxt    = stat_r;
      op_nxt      = op_r;
      amt_nxt     = amt_r;
      clr_mask    = '0;
      grant_act   = 1'b0;
      grant_decay = 1'b0;
      upd_valid   = 1'b0;

      unique case (state)
         IDLE: begin
            if (ena) begin
               if ((act_pend != '0) && !(starve && decay_pend)) begin
                  grant_act = 1'b1;
                  state_nxt = ACT;
                  stat_nxt  = act_idx;
                  op_nxt    = OP_INC;
                  amt_nxt   = {2'b00, rand_in[1:0]} + 4'd1;
                  clr_mask  = NUM_STATS'(1) << act_idx;
               end else if (decay_pend) begin
                  grant_decay = 1'b1;
                  state_nxt   = DECAY;
                  idx_nxt     = HUNGER;
                  op_nxt      = OP_DEC;
                  amt_nxt     = DECAY_AMT;
               end
            end
         end
         ACT: begin
            upd_valid = 1'b1;
            if (upd_ready) begin
               state_nxt = COOL;
               cnt_nxt   = COOLDOWN - 8'd1;
            end
         end
         DECAY: begin
            upd_valid = 1'b1;
            if (upd_ready) begin
               if (idx == SOCIAL) begin
                  state_nxt = IDLE;
                  idx_nxt   = HUNGER;
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end
         end
         COOL: begin
            if (cnt == 8'd0) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 8'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         presc      <= 24'd0;
         decay_pend <= 1'b0;
         idx        <= 3'd0;
         cnt        <= 8'd0;
         stat_r     <= 3'd0;
         op_r       <= 1'b0;
         amt_r      <= 4'd0;
      end else begin
         state      <= state_nxt;
         presc      <= presc_nxt;
         decay_pend <= decay_pend_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         stat_r     <= stat_nxt;
         op_r       <= op_nxt;
         amt_r      <= amt_nxt;
      end
   end

   assign upd_stat = (state == DECAY) ? idx : stat_r;
   assign upd_op   = op_r;
   assign upd_amt  = amt_r;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_care_scheduler.sv
// tb_care_scheduler -- directed bench for care_scheduler with
// TICK_COUNT=8, COOLDOWN=4. Handshakes are logged into a queue as
// {stat, op, amt} and compared against hand-computed sequences.
module tb_care_scheduler;
   import care_sched_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [5:0] btn_in;
   logic [3:0] rand_in;
   logic       upd_valid;
   logic       upd_ready;
   logic [2:0] upd_stat;
   logic       upd_op;
   logic [3:0] upd_amt;
   logic       tick;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] hs_q[$];

   always #5 clk = ~clk;

   care_scheduler #(
      .TICK_COUNT (24'd8),
      .COOLDOWN   (8'd4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .btn_in    (btn_in),
      .rand_in   (rand_in),
      .upd_valid (upd_valid),
      .upd_ready (upd_ready),
      .upd_stat  (upd_stat),
      .upd_op    (upd_op),
      .upd_amt   (upd_amt),
      .tick      (tick),
      .busy      (busy)
   );

   // Inputs are stable at the falling edge, so a valid&ready seen here is
   // the handshake taken at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && upd_valid && upd_ready) hs_q.push_back({upd_stat, upd_op, upd_amt});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      ena       = 1'b0;
      btn_in    = 6'b0;
      rand_in   = 4'b0;
      upd_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outputs", {upd_valid, upd_stat, upd_op, upd_amt, tick, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hs_q.delete();
      cyc();
   endtask

   task automatic wait_hs(input int n, input int budget, input string tag);
      int k = 0;
      while (hs_q.size() < n && k < budget) begin
         cyc();
         k++;
      end
      chk(tag, 32'(hs_q.size() >= n), 32'd1);
   endtask

   task automatic check_hs(input int i, input string tag,
                           input logic [2:0] s, input logic o, input logic [3:0] a);
      logic [7:0] got;
      got = (i < hs_q.size()) ? hs_q[i] : 8'hff;
      chk(tag, 32'(got), 32'({s, o, a}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Decay period and full sweep
      do_reset();
      ena = 1'b1;
      #1;
      for (int c = 1; c <= 8; c++) begin
         chk($sformatf("t1_tick_c%0d", c), 32'(tick), 32'(c == 8));
         cyc();
      end
      chk("t1_idle_before_grant", 32'(busy), 32'd0);
      cyc();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t1_valid_%0d", i), 32'(upd_valid), 32'd1);
         chk($sformatf("t1_stat_%0d", i), 32'(upd_stat), 32'(i));
         cyc();
      end
      wait_hs(6, 10, "t1_hs_count");
      for (int i = 0; i < 6; i++) check_hs(i, $sformatf("t1_hs_%0d", i), 3'(i), OP_DEC, 4'd1);
      chk("t1_idle_after", 32'(busy), 32'd0);

      // Single action then cooldown
      do_reset();
      ena     = 1'b1;
      btn_in  = 6'b000100;
      rand_in = 4'b0010;
      cyc();
      chk("t2_grant_cycle_idle", 32'(busy), 32'd0);
      cyc();
      chk("t2_act_valid", 32'(upd_valid), 32'd1);
      chk("t2_act_stat", 32'(upd_stat), 32'd2);
      chk("t2_act_op", 32'(upd_op), 32'd1);
      chk("t2_act_amt", 32'(upd_amt), 32'd3);
      chk("t2_act_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("t2_cool_busy_%0d", i), 32'(busy), 32'd1);
         chk($sformatf("t2_cool_valid_%0d", i), 32'(upd_valid), 32'd0);
      end
      cyc();
      chk("t2_idle_after_cool", 32'(busy), 32'd0);
      cyc();
      chk("t2_no_regrant", 32'(busy), 32'd0);
      chk("t2_hs_count", 32'(hs_q.size()), 32'd1);
      check_hs(0, "t2_hs_0", 3'd2, OP_INC, 4'd3);

      // Two simultaneous presses, lowest index first
      do_reset();
      ena     = 1'b1;
      btn_in  = 6'b100010;
      rand_in = 4'b0000;
      cyc();
      cyc();
      chk("t3_first_stat", 32'(upd_stat), 32'd1);
      rand_in = 4'b1111;
      wait_hs(8, 60, "t3_hs_count");
      check_hs(0, "t3_hs_0", 3'd1, OP_INC, 4'd1);
      check_hs(1, "t3_hs_1", 3'd5, OP_INC, 4'd4);
      for (int i = 0; i < 6; i++) check_hs(i + 2, $sformatf("t3_decay_%0d", i), 3'(i), OP_DEC, 4'd1);

      // Back-pressure in the middle of a sweep
      do_reset();
      ena = 1'b1;
      repeat (12) cyc();
      chk("t4_at_idx3", 32'({upd_valid, upd_stat}), 32'({1'b1, 3'd3}));
      upd_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk($sformatf("t4_hold_%0d", i), 32'({upd_valid, upd_stat, upd_op, upd_amt}),
             32'({1'b1, 3'd3, 1'b0, 4'd1}));
      end
      upd_ready = 1'b1;
      wait_hs(6, 20, "t4_hs_count");
      for (int i = 0; i < 6; i++) check_hs(i, $sformatf("t4_hs_%0d", i), 3'(i), OP_DEC, 4'd1);

      // ena dropped mid-cooldown with a press pending
      do_reset();
      ena     = 1'b1;
      btn_in  = 6'b000001;
      rand_in = 4'b0000;
      cyc();
      cyc();
      chk("t5_act_stat", 32'(upd_stat), 32'd0);
      cyc();
      chk("t5_in_cool", 32'({busy, upd_valid}), 32'b10);
      btn_in = 6'b001001;
      cyc();
      ena = 1'b0;
      cyc();
      chk("t5_cool_a", 32'(busy), 32'd1);
      cyc();
      chk("t5_cool_b", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("t5_blocked_%0d", i), 32'(busy), 32'd0);
      end
      ena = 1'b1;
      cyc();
      chk("t5_grant_after_ena", 32'({upd_valid, upd_stat, upd_op}), 32'({1'b1, 3'd3, 1'b1}));

      // Reset during a stalled action
      do_reset();
      ena       = 1'b1;
      upd_ready = 1'b0;
      btn_in    = 6'b010000;
      cyc();
      cyc();
      chk("t6_act_before_rst", 32'({upd_valid, upd_stat}), 32'({1'b1, 3'd4}));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_valid_in_rst", 32'(upd_valid), 32'd0);
      chk("t6_busy_in_rst", 32'(busy), 32'd0);
      btn_in = 6'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      upd_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk($sformatf("t6_no_stale_%0d", i), 32'(busy), 32'd0);
      end
      chk("t6_hs_count", 32'(hs_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/care_scheduler.md
CARE_SCHEDULER -- requirements
Module: care_scheduler

Interface
REQ-001 SHALL have parameter TICK_COUNT, default 24'd10_000_000, meaning the decay period in clk cycles (legal range >= 2).
REQ-002 SHALL have parameter COOLDOWN, default 8'd16, meaning the lockout cycles after each action update (legal range >= 1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ena, input, 1 bit: design enable.
REQ-006 SHALL have port btn_in, input, 6 bits: care buttons; bit i maps to stat i.
REQ-007 SHALL have port rand_in, input, 4 bits: random value from the random source.
REQ-008 SHALL have port upd_valid, output, 1 bit: update request to the stats datapath.
REQ-009 SHALL have port upd_ready, input, 1 bit: the stats datapath accepts the update.
REQ-010 SHALL have port upd_stat, output, 3 bits: target stat index, 0..5.
REQ-011 SHALL have port upd_op, output, 1 bit: 0 = decrement, 1 = increment.
REQ-012 SHALL have port upd_amt, output, 4 bits: update magnitude.
REQ-013 SHALL have port tick, output, 1 bit: one-cycle pulse at each decay period.
REQ-014 SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-015 The prescaler SHALL count 0..TICK_COUNT-1 while ena=1, hold its value while ena=0, and wrap to 0 at terminal count.
- At terminal count: tick=1 for that cycle and decay_pend is set.
REQ-016 A tick that occurs while decay_pend is already set SHALL be absorbed, with no counting of missed ticks.
REQ-017 Rising-edge detection SHALL use btn_q <= btn_in, rise = btn_in & ~btn_q, and each rise[i] SHALL set act_pend[i].
REQ-018 A pending bit SHALL clear on its grant; a new rise on the same bit in the grant cycle SHALL leave the bit set.
REQ-019 The FSM SHALL have states IDLE, ACT, DECAY and COOL.
REQ-020 In IDLE with ena=1, the FSM SHALL grant as follows:
- If act_pend != 0: go to ACT with upd_stat = lowest set index, upd_op=1, upd_amt = {2'b00,rand_in[1:0]}+1 (1..4, captured at grant).
- Else if decay_pend: go to DECAY with idx=0, upd_op=0, upd_amt=1, and clear decay_pend on entry.
REQ-021 In ACT, upd_valid SHALL be 1 with fields stable until upd_ready; on upd_valid&upd_ready the FSM SHALL go to COOL with cnt=COOLDOWN-1.
REQ-022 In DECAY, upd_valid SHALL be 1 with upd_stat=idx; on each handshake idx SHALL increment, and after idx=5 the FSM SHALL return to IDLE.
- A full sweep is exactly 6 handshakes.
REQ-023 In COOL, cnt SHALL decrement each cycle, and the FSM SHALL go to IDLE in the cycle after cnt=0.
- Buttons SHALL continue to latch during COOL, ACT and DECAY.
REQ-024 upd_valid SHALL be low in IDLE and COOL; no grant SHALL occur in the same cycle as a handshake.
- Minimum spacing is 1 IDLE cycle.
REQ-025 ena=0 SHALL block new grants from IDLE only; an in-flight ACT, DECAY or COOL SHALL complete normally.
REQ-026 Once asserted, upd_valid SHALL NOT drop before the handshake.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously clear the following: state=IDLE, prescaler=0, decay_pend=0, act_pend=0, btn_q=0, idx=0, cnt=0.
REQ-028 Outputs under reset SHALL be: upd_valid=0, upd_stat=0, upd_op=0, upd_amt=0, tick=0, busy=0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer, drop upd_valid immediately and discard all pending requests.

Configuration
REQ-030 With SCHED_STARVE_GUARD_EN defined, a 3-bit streak counter SHALL count consecutive ACT grants while decay_pend=1.
- When the streak reaches 4, IDLE SHALL grant DECAY ahead of pending actions.
- The streak SHALL clear on DECAY entry or reset.
REQ-031 Without SCHED_STARVE_GUARD_EN, actions SHALL have strict priority and no streak logic SHALL exist.

Structure
REQ-032 Package care_sched_pkg SHALL hold the following:
- State encoding.
- Stat indices: HUNGER=0, HAPPINESS=1, HEALTH=2, HYGIENE=3, ENERGY=4, SOCIAL=5.
- NUM_STATS=6.
- Op codes OP_DEC=0, OP_INC=1.
- DECAY_AMT=1.
REQ-033 Edge detection and pending latches SHALL be one sub-module, btn_edge_latch (6-bit, with a clear-mask input); all else SHALL be in care_scheduler.

Verification (bench: TICK_COUNT=8, COOLDOWN=4, upd_ready=1 unless noted)
REQ-034 Reset then ena=1 for 8 cycles -> tick pulses in cycle 8; six DECAY handshakes follow with upd_stat 0..5, upd_op=0, upd_amt=1.
REQ-035 btn_in=6'b000100 with rand_in=4'b0010 -> ACT with upd_stat=2, upd_op=1, upd_amt=3; then 4 COOL cycles and busy=1 throughout.
REQ-036 btn_in rises on bits 5 and 1 in the same cycle -> grant stat 1 first, stat 5 after COOL; each pending bit cleared exactly once.
REQ-037 upd_ready=0 for 10 cycles during DECAY idx=3 -> upd_valid, upd_stat and upd_amt held stable; the sweep resumes at idx=3 and does not restart.
REQ-038 ena=0 asserted mid-COOL with a button pending -> COOL completes and FSM stays in IDLE; grant occurs 1 cycle after ena=1.
REQ-039 rst_n=0 while in ACT with upd_ready=0 -> upd_valid=0 and busy=0 in the same cycle; after release no stale grant occurs.
